// File: rtl/ahb_mesh_mem.sv
// AHB slave for one mesh node: local accesses hit a word RAM; remote accesses become queued mesh headers.
// Latency: local read/write zero wait; remote write completes on push; remote read completes on rx_valid.
// Backpressure: full header queue (registered count) stalls HREADYOUT; consumer drains via tx_valid/tx_ready.
//
// Ports:
//   HCLK, HRESET                      clock, synchronous active-high reset
//   HADDR/HWDATA/HSIZE/HTRANS/HWRITE/HREADY/HSEL -> HRDATA/HREADYOUT   AHB slave side
//   tx_valid/tx_ready, Mem_Addr, Mem_Data, Des_Addr, Byte_Len, Mes_Type  outgoing header queue head
//   rx_valid, rx_data                 remote read response
//   txq_count                         header queue occupancy
module ahb_mesh_mem #(
   parameter int ADDRX       = 0,
   parameter int ADDRY       = 0,
   parameter int XY_BITS     = 2,
   parameter int LOCAL_WORDS = 256,
   parameter int TXQ_DEPTH   = 4,
   localparam int CNT_W      = $clog2(TXQ_DEPTH) + 1
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic [31:0]      HADDR,
   input  logic [31:0]      HWDATA,
   input  logic [2:0]       HSIZE,
   input  logic [1:0]       HTRANS,
   input  logic             HWRITE,
   input  logic             HREADY,
   input  logic             HSEL,
   output logic [31:0]      HRDATA,
   output logic             HREADYOUT,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic [31:0]      Mem_Addr,
   output logic [31:0]      Mem_Data,
   output logic [7:0]       Des_Addr,
   output logic [7:0]       Byte_Len,
   output logic [7:0]       Mes_Type,
   input  logic             rx_valid,
   input  logic [31:0]      rx_data,
   output logic [CNT_W-1:0] txq_count
);

   localparam int NODE_W = 2 * XY_BITS;
   localparam int IDX_W  = $clog2(LOCAL_WORDS);
   localparam int PTR_W  = $clog2(TXQ_DEPTH);

   localparam logic [XY_BITS-1:0] NODE_X     = XY_BITS'(ADDRX);
   localparam logic [XY_BITS-1:0] NODE_Y     = XY_BITS'(ADDRY);
   localparam logic [NODE_W-1:0]  LOCAL_NODE = {NODE_X, NODE_Y};

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [7:0]  dest;
      logic [7:0]  len;
      logic [7:0]  mtype;
   } hdr_t;

   typedef enum logic [1:0] {ST_IDLE, ST_PUSH_WAIT, ST_RD_WAIT} state_t;

   state_t state_q, state_d;

   // Captured address phase
   logic        ph_vld_q;
   logic        ph_wr_q;
   logic        ph_remote_q;
   logic [31:0] ph_addr_q;
   logic [2:0]  ph_size_q;

   // Local memory (never reset)
   logic [31:0] mem_q [LOCAL_WORDS];
   logic [IDX_W-1:0] mem_idx;
   logic [3:0]       lane_mask;
   logic             mem_we;

   // Header queue
   hdr_t             txq_q [TXQ_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             txq_full;
   logic             push, pop;
   hdr_t             push_hdr, head;
   logic [7:0]       byte_len;

   assign mem_idx  = ph_addr_q[2 +: IDX_W];
   assign txq_full = (count_q == CNT_W'(TXQ_DEPTH));
   assign tx_valid = (count_q != '0);
   assign pop      = tx_valid && tx_ready;
   assign mem_we   = (state_q == ST_IDLE) && ph_vld_q && ph_wr_q && !ph_remote_q && !HRESET;

   always_comb begin
      byte_len = 8'd4;
      case (ph_size_q)
         3'd0:    byte_len = 8'd1;
         3'd1:    byte_len = 8'd2;
         default: byte_len = 8'd4;
      endcase
   end

   always_comb begin
      lane_mask = 4'b1111;
      case (ph_size_q)
         3'd0:    lane_mask = 4'b0001 << ph_addr_q[1:0];
         3'd1:    lane_mask = ph_addr_q[1] ? 4'b1100 : 4'b0011;
         default: lane_mask = 4'b1111;
      endcase
   end

   always_comb begin
      push_hdr       = '0;
      push_hdr.addr  = ph_addr_q;
      push_hdr.data  = ph_wr_q ? HWDATA : 32'd0;
      push_hdr.dest  = 8'(ph_addr_q[24 +: NODE_W]);
      push_hdr.len   = byte_len;
      push_hdr.mtype = ph_wr_q ? 8'd1 : 8'd3;
   end

   // Control FSM. Full is judged on the registered count only, so a pop in
   // the same cycle never opens a push slot (no tx_ready -> HREADYOUT path).
   always_comb begin
      state_d   = state_q;
      push      = 1'b0;
      HREADYOUT = 1'b1;
      HRDATA    = 32'd0;
      case (state_q)
         ST_IDLE: begin
            if (ph_vld_q) begin
               if (!ph_remote_q) begin
                  if (!ph_wr_q) HRDATA = mem_q[mem_idx];
               end else if (txq_full) begin
                  HREADYOUT = 1'b0;
                  state_d   = ST_PUSH_WAIT;
               end else begin
                  push = 1'b1;
                  if (!ph_wr_q) begin
                     HREADYOUT = 1'b0;
                     state_d   = ST_RD_WAIT;
                  end
               end
            end
         end
         ST_PUSH_WAIT: begin
            if (txq_full) begin
               HREADYOUT = 1'b0;
            end else begin
               push = 1'b1;
               if (ph_wr_q) begin
                  state_d = ST_IDLE;
               end else begin
                  HREADYOUT = 1'b0;
                  state_d   = ST_RD_WAIT;
               end
            end
         end
         ST_RD_WAIT: begin
            if (rx_valid) begin
               HRDATA  = rx_data;
               state_d = ST_IDLE;
            end else begin
               HREADYOUT = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= ST_IDLE;
         ph_vld_q    <= 1'b0;
         ph_wr_q     <= 1'b0;
         ph_remote_q <= 1'b0;
         ph_addr_q   <= '0;
         ph_size_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q <= state_d;
         // A stalled data phase keeps its captured address phase.
         if (HREADY && HREADYOUT) begin
            ph_vld_q    <= HSEL && (HTRANS != 2'b00);
            ph_wr_q     <= HWRITE;
            ph_remote_q <= (HADDR[24 +: NODE_W] != LOCAL_NODE);
            ph_addr_q   <= HADDR;
            ph_size_q   <= HSIZE;
         end
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge HCLK) begin
      if (push) txq_q[wr_ptr_q] <= push_hdr;
   end

   always_ff @(posedge HCLK) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_mask[b]) mem_q[mem_idx][8*b +: 8] <= HWDATA[8*b +: 8];
         end
      end
   end

   // Head is forced to zero when empty so stale storage never shows after reset.
   assign head      = tx_valid ? txq_q[rd_ptr_q] : '0;
   assign Mem_Addr  = head.addr;
   assign Mem_Data  = head.data;
   assign Des_Addr  = head.dest;
   assign Byte_Len  = head.len;
   assign Mes_Type  = head.mtype;
   assign txq_count = count_q;

endmodule

// File: tb/tb_ahb_mesh_mem.sv
// Directed bench for ahb_mesh_mem at node (1,2): local RAM, remote header queue, remote read, reset abort.
// Inputs change #1 after the rising edge, outputs are sampled on the falling edge.
// HREADY loops back from HREADYOUT, as for a single slave on the bus.
module tb_ahb_mesh_mem;

   logic        HCLK;
   logic        HRESET;
   logic [31:0] HADDR;
   logic [31:0] HWDATA;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic        HREADY;
   logic        HSEL;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] Mem_Addr;
   logic [31:0] Mem_Data;
   logic [7:0]  Des_Addr;
   logic [7:0]  Byte_Len;
   logic [7:0]  Mes_Type;
   logic        rx_valid;
   logic [31:0] rx_data;
   logic [2:0]  txq_count;

   int n_pass  = 0;
   int n_total = 0;

   // Expected queue contents for the five-write burst
   logic [31:0] exp_addr [5] = '{32'h0000_0100, 32'h0100_0104, 32'h0F00_0108, 32'h0300_010C, 32'h0A00_0110};
   logic [31:0] exp_data [5] = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hC0DE_0004};
   logic [2:0]  exp_size [5] = '{3'd2, 3'd0, 3'd1, 3'd3, 3'd2};
   logic [7:0]  exp_len  [5] = '{8'd4, 8'd1, 8'd2, 8'd4, 8'd4};
   logic [7:0]  exp_dest [5] = '{8'h00, 8'h01, 8'h0F, 8'h03, 8'h0A};
   logic [2:0]  exp_cnt  [5] = '{3'd4, 3'd3, 3'd3, 3'd2, 3'd1};

   assign HREADY = HREADYOUT;

   ahb_mesh_mem #(
      .ADDRX       (1),
      .ADDRY       (2),
      .XY_BITS     (2),
      .LOCAL_WORDS (256),
      .TXQ_DEPTH   (4)
   ) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .HADDR     (HADDR),
      .HWDATA    (HWDATA),
      .HSIZE     (HSIZE),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HREADY    (HREADY),
      .HSEL      (HSEL),
      .HRDATA    (HRDATA),
      .HREADYOUT (HREADYOUT),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .Mem_Addr  (Mem_Addr),
      .Mem_Data  (Mem_Data),
      .Des_Addr  (Des_Addr),
      .Byte_Len  (Byte_Len),
      .Mes_Type  (Mes_Type),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .txq_count (txq_count)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic sample();
      @(negedge HCLK);
   endtask

   task automatic addr_ph(input logic wr, input logic [31:0] a, input logic [2:0] sz);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = wr;
      HADDR  = a;
      HSIZE  = sz;
   endtask

   task automatic idle_ph();
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
      HADDR  = 32'd0;
      HSIZE  = 3'd0;
   endtask

   task automatic chk_head(input string tag, input int k);
      chk({tag, "_addr"}, Mem_Addr, exp_addr[k]);
      chk({tag, "_data"}, Mem_Data, exp_data[k]);
      chk({tag, "_dest"}, 32'(Des_Addr), 32'(exp_dest[k]));
      chk({tag, "_len"},  32'(Byte_Len), 32'(exp_len[k]));
      chk({tag, "_type"}, 32'(Mes_Type), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      HRESET   = 1'b1;
      HWDATA   = 32'd0;
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 32'd0;
      idle_ph();
      step();
      step();
      HRESET = 1'b0;

      // Reset state
      sample();
      chk("rst_hreadyout", HREADYOUT, 32'd1);
      chk("rst_hrdata", HRDATA, 32'd0);
      chk("rst_tx_valid", tx_valid, 32'd0);
      chk("rst_txq_count", txq_count, 32'd0);
      chk("rst_mem_addr", Mem_Addr, 32'd0);
      chk("rst_mes_type", Mes_Type, 32'd0);
      step();

      // Local word write then read back
      addr_ph(1'b1, 32'h0600_0010, 3'd2);
      step();
      HWDATA = 32'hDEAD_BEEF;
      addr_ph(1'b0, 32'h0600_0010, 3'd2);
      sample();
      chk("lwr_hreadyout", HREADYOUT, 32'd1);
      step();
      idle_ph();
      HWDATA = 32'd0;
      sample();
      chk("lrd_data", HRDATA, 32'hDEAD_BEEF);
      chk("lrd_hreadyout", HREADYOUT, 32'd1);
      step();
      sample();
      chk("idle_hrdata", HRDATA, 32'd0);
      chk("local_no_push", tx_valid, 32'd0);
      chk("local_no_count", txq_count, 32'd0);
      step();

      // Byte write into lane 3, then halfword into lanes 3:2
      addr_ph(1'b1, 32'h0600_0010, 3'd2);
      step();
      HWDATA = 32'h1122_3344;
      addr_ph(1'b1, 32'h0600_0013, 3'd0);
      step();
      HWDATA = 32'hAA55_AA55;
      addr_ph(1'b0, 32'h0600_0010, 3'd2);
      step();
      idle_ph();
      sample();
      chk("byte_wr", HRDATA, 32'hAA22_3344);
      step();
      addr_ph(1'b1, 32'h0600_0012, 3'd1);
      step();
      HWDATA = 32'hBEEF_0000;
      addr_ph(1'b0, 32'h0600_0010, 3'd2);
      step();
      idle_ph();
      sample();
      chk("half_wr", HRDATA, 32'hBEEF_3344);
      step();

      // Single remote write with consumer ready
      tx_ready = 1'b1;
      addr_ph(1'b1, 32'h0300_0020, 3'd2);
      step();
      HWDATA = 32'h0000_0055;
      idle_ph();
      sample();
      chk("rwr_hreadyout", HREADYOUT, 32'd1);
      chk("rwr_not_yet_valid", tx_valid, 32'd0);
      step();
      sample();
      chk("rwr_tx_valid", tx_valid, 32'd1);
      chk("rwr_mem_addr", Mem_Addr, 32'h0300_0020);
      chk("rwr_mem_data", Mem_Data, 32'h0000_0055);
      chk("rwr_des_addr", Des_Addr, 32'h03);
      chk("rwr_byte_len", Byte_Len, 32'd4);
      chk("rwr_mes_type", Mes_Type, 32'd1);
      step();
      sample();
      chk("rwr_drained", tx_valid, 32'd0);
      chk("rwr_head_zero", Mem_Addr, 32'd0);
      step();

      // Five remote writes into a depth-4 queue with consumer stalled
      tx_ready = 1'b0;
      addr_ph(1'b1, exp_addr[0], exp_size[0]);
      step();
      for (int i = 1; i < 5; i++) begin
         HWDATA = exp_data[i-1];
         addr_ph(1'b1, exp_addr[i], exp_size[i]);
         sample();
         chk("fill_hreadyout", HREADYOUT, 32'd1);
         step();
      end
      HWDATA = exp_data[4];
      idle_ph();
      sample();
      chk("full_stall", HREADYOUT, 32'd0);
      chk("full_count", txq_count, 32'd4);
      chk_head("full_head0", 0);
      step();
      tx_ready = 1'b1;
      sample();
      chk("pop_cycle_still_stalled", HREADYOUT, 32'd0);
      chk("pop_cycle_count", txq_count, 32'(exp_cnt[0]));
      chk_head("stable_head0", 0);
      step();
      sample();
      chk("fifth_completes", HREADYOUT, 32'd1);
      chk("pushpop_count", txq_count, 32'(exp_cnt[1]));
      chk_head("head1", 1);
      step();
      HWDATA = 32'd0;
      for (int k = 2; k < 5; k++) begin
         sample();
         chk("drain_count", txq_count, 32'(exp_cnt[k]));
         chk_head("drain_head", k);
         step();
      end
      sample();
      chk("drain_empty_valid", tx_valid, 32'd0);
      chk("drain_empty_count", txq_count, 32'd0);
      step();

      // Remote read, response three cycles after the data phase starts
      addr_ph(1'b0, 32'h0200_0040, 3'd2);
      step();
      idle_ph();
      sample();
      chk("rrd_wait1", HREADYOUT, 32'd0);
      step();
      sample();
      chk("rrd_wait2", HREADYOUT, 32'd0);
      chk("rrd_tx_valid", tx_valid, 32'd1);
      chk("rrd_mem_addr", Mem_Addr, 32'h0200_0040);
      chk("rrd_mem_data", Mem_Data, 32'd0);
      chk("rrd_des_addr", Des_Addr, 32'h02);
      chk("rrd_mes_type", Mes_Type, 32'd3);
      step();
      sample();
      chk("rrd_wait3", HREADYOUT, 32'd0);
      step();
      rx_valid = 1'b1;
      rx_data  = 32'h0000_1234;
      sample();
      chk("rrd_done_rdy", HREADYOUT, 32'd1);
      chk("rrd_done_data", HRDATA, 32'h0000_1234);
      step();
      rx_data = 32'h0000_FFFF;
      sample();
      chk("rx_ignored_data", HRDATA, 32'd0);
      chk("rx_ignored_rdy", HREADYOUT, 32'd1);
      step();
      rx_valid = 1'b0;

      // Reset while waiting on a remote read with two headers queued
      tx_ready = 1'b0;
      addr_ph(1'b1, 32'h0100_0000, 3'd2);
      step();
      HWDATA = 32'h0000_0077;
      addr_ph(1'b0, 32'h0100_0004, 3'd2);
      sample();
      chk("abort_wr_rdy", HREADYOUT, 32'd1);
      step();
      idle_ph();
      sample();
      chk("abort_rd_stall", HREADYOUT, 32'd0);
      step();
      sample();
      chk("abort_queued", txq_count, 32'd2);
      chk("abort_in_wait", HREADYOUT, 32'd0);
      HRESET = 1'b1;
      step();
      HRESET   = 1'b0;
      rx_valid = 1'b1;
      rx_data  = 32'h0000_0BAD;
      sample();
      chk("abort_hreadyout", HREADYOUT, 32'd1);
      chk("abort_tx_valid", tx_valid, 32'd0);
      chk("abort_count", txq_count, 32'd0);
      chk("abort_head_zero", Mem_Addr, 32'd0);
      chk("abort_rx_ignored", HRDATA, 32'd0);
      step();
      rx_valid = 1'b0;
      rx_data  = 32'd0;

      // Local RAM survives reset
      addr_ph(1'b0, 32'h0600_0010, 3'd2);
      step();
      idle_ph();
      sample();
      chk("mem_kept", HRDATA, 32'hBEEF_3344);
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
